// File: rtl/phase_acc_pkg.sv
// Shared constants for the phase accumulator slice.
//   PHASE_W_DEF : accumulator / frequency control word width
//   ADDR_W_DEF  : phase MSBs emitted per output word
//   CHUNK_W_DEF : bits emitted per clock; ADDR_W must be a multiple of it
//   NCH_DEF     : chunks per word (ADDR_W / CHUNK_W)
package phase_acc_pkg;

  localparam int PHASE_W_DEF = 20;
  localparam int ADDR_W_DEF  = 12;
  localparam int CHUNK_W_DEF = 2;
  localparam int NCH_DEF     = ADDR_W_DEF / CHUNK_W_DEF;

  // Width of a counter over 0..n-1. A single-chunk word still gets one bit
  // so the counter port never collapses to zero width.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pa_serializer.sv
// Chunk serializer: latches an ADDR_W-bit word every NCH cycles and emits it
// CHUNK_W bits per clock, most significant chunk first.
//   clk, rstn : clock, asynchronous active-low reset
//   en        : 1 = run, 0 = clear all state and outputs
//   word_in   : word to latch on the frame-start edge (cnt == 0)
//   cnt       : frame counter, 0..NCH-1 (also the observable state)
//   vld       : aout/isout carry stream data
//   aout      : current chunk
//   isout     : high on the first chunk of each word
//
// Stream semantics: there is no back-pressure. Every cycle with vld=1 carries
// exactly one chunk; the consumer must accept it in that cycle. isout marks
// the first chunk of a word, and words follow back-to-back with no gaps.
module pa_serializer
  import phase_acc_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF,
  localparam int NCH    = ADDR_W / CHUNK_W,
  localparam int CNT_W  = cnt_width(NCH)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [ADDR_W-1:0]  word_in,
  output logic [CNT_W-1:0]   cnt,
  output logic               vld,
  output logic [CHUNK_W-1:0] aout,
  output logic               isout
);

  logic [ADDR_W-1:0]  w_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CHUNK_W-1:0] chunk [NCH];

  // chunk[k] is slice k of the held word, counted from the MSB end.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
    assign chunk[gi] = w_q[ADDR_W-1-gi*CHUNK_W -: CHUNK_W];
  end

  always_comb begin
    cnt_nxt = cnt + 1'b1;
    if (cnt == CNT_W'(NCH - 1)) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_q   <= '0;
      cnt   <= '0;
      vld   <= 1'b0;
      aout  <= '0;
      isout <= 1'b0;
    end else if (!en) begin
      w_q   <= '0;
      cnt   <= '0;
      vld   <= 1'b0;
      aout  <= '0;
      isout <= 1'b0;
    end else if (cnt == '0) begin
      // The top chunk comes straight from word_in: w_q is only being
      // loaded on this edge, so it cannot supply it yet.
      w_q   <= word_in;
      aout  <= word_in[ADDR_W-1 -: CHUNK_W];
      isout <= 1'b1;
      vld   <= 1'b1;
      cnt   <= cnt_nxt;
    end else begin
      aout  <= chunk[cnt];
      isout <= 1'b0;
      vld   <= 1'b1;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/phase_accumulator.sv
// Phase accumulator with serialized phase-address output.
// The phase register advances by FCW once per word; the top ADDR_W bits of
// the phase in force at each word start are streamed out CHUNK_W bits/clock.
//   clk   : clock, all state on its rising edge
//   rstn  : asynchronous active-low reset
//   En    : 1 = run, 0 = clear phase and idle
//   FCW   : frequency control word (unsigned), sampled at word start only
//   Vld   : Aout/ISout carry valid stream data
//   Aout  : current address chunk, MSB chunk first
//   ISout : start-of-word flag
module phase_accumulator
  import phase_acc_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               En,
  input  logic [PHASE_W-1:0] FCW,
  output logic               Vld,
  output logic [CHUNK_W-1:0] Aout,
  output logic               ISout
);

  localparam int NCH   = ADDR_W / CHUNK_W;
  localparam int CNT_W = cnt_width(NCH);

  logic [PHASE_W-1:0] p_q;
  logic [CNT_W-1:0]   ser_cnt;
  logic               word_start;

  // The phase only moves on the edge where the serializer takes a new word,
  // so FCW changes mid-word land at the next word boundary.
  assign word_start = (ser_cnt == '0);

  // Modulo-2^PHASE_W wrap is the natural truncation of the adder.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_q <= '0;
    end else if (!En) begin
      p_q <= '0;
    end else if (word_start) begin
      p_q <= p_q + FCW;
    end
  end

  pa_serializer #(
    .ADDR_W  (ADDR_W),
    .CHUNK_W (CHUNK_W)
  ) u_ser (
    .clk     (clk),
    .rstn    (rstn),
    .en      (En),
    .word_in (p_q[PHASE_W-1 -: ADDR_W]),
    .cnt     (ser_cnt),
    .vld     (Vld),
    .aout    (Aout),
    .isout   (ISout)
  );

endmodule

// File: tb/tb_phase_accumulator.sv
module tb_phase_accumulator;

  localparam int PW  = 20;
  localparam int AW  = 12;
  localparam int CW  = 2;
  localparam int NCH = AW / CW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rstn;
  logic          en;
  logic [PW-1:0] fcw;
  logic          vld;
  logic [CW-1:0] aout;
  logic          isout;

  always #5 clk = ~clk;

  phase_accumulator #(.PHASE_W(PW), .ADDR_W(AW), .CHUNK_W(CW)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .En    (en),
    .FCW   (fcw),
    .Vld   (vld),
    .Aout  (aout),
    .ISout (isout)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- behavioural model ----------------
  // Each entry is {isout, chunk}. When the queue runs dry a new word is
  // generated from the running phase and split into NCH chunks.
  logic [CW:0]   exp_q[$];
  logic [PW-1:0] m_phase;
  logic          cur_vld;
  logic          cur_is;
  logic [CW-1:0] cur_aout;

  task automatic model_clear();
    m_phase  = '0;
    exp_q.delete();
    cur_vld  = 1'b0;
    cur_is   = 1'b0;
    cur_aout = '0;
  endtask

  initial begin
    logic [AW-1:0] word;
    logic [CW:0]   e;
    model_clear();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn || !en) begin
        model_clear();
      end else begin
        if (exp_q.size() == 0) begin
          word = AW'(m_phase >> (PW - AW));
          for (int i = 0; i < NCH; i++) begin
            exp_q.push_back({(i == 0), CW'(word >> (AW - (i + 1) * CW))});
          end
          m_phase = m_phase + fcw;
        end
        e        = exp_q.pop_front();
        cur_vld  = 1'b1;
        cur_is   = e[CW];
        cur_aout = e[CW-1:0];
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare + word collector ----------------
  logic [AW-1:0] got_q[$];
  logic [AW-1:0] acc;
  int            acc_n = 0;

  initial begin
    forever begin
      @(negedge clk);
      tests++;
      if ({vld, isout, aout} !== {cur_vld, cur_is, cur_aout}) begin
        fails++;
        $display("FAIL stream t=%0t got vld=%b is=%b a=%b want vld=%b is=%b a=%b",
                 $time, vld, isout, aout, cur_vld, cur_is, cur_aout);
      end
      if (!vld) begin
        acc_n = 0;
      end else if (isout) begin
        acc   = AW'(aout);
        acc_n = 1;
      end else if (acc_n > 0) begin
        acc   = {acc[AW-CW-1:0], aout};
        acc_n = acc_n + 1;
      end
      if (acc_n == NCH) begin
        got_q.push_back(acc);
        acc_n = 0;
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk_out(input string name, input logic [CW+1:0] exp);
    tests++;
    if ({vld, isout, aout} !== exp) begin
      fails++;
      $display("FAIL %s got {vld,is,a}=%b want %b", name, {vld, isout, aout}, exp);
    end
  endtask

  task automatic chk_word(input string name, input int idx, input logic [AW-1:0] exp);
    tests++;
    if (idx >= got_q.size()) begin
      fails++;
      $display("FAIL %s word %0d missing (have %0d) want %h", name, idx, got_q.size(), exp);
    end else if (got_q[idx] !== exp) begin
      fails++;
      $display("FAIL %s word %0d got %h want %h", name, idx, got_q[idx], exp);
    end
  endtask

  task automatic run_words(input logic [PW-1:0] f, input int nwords);
    got_q.delete();
    fcw = f;
    en  = 1'b1;
    step(nwords * NCH);
    en  = 1'b0;
    step(1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rstn = 1'b0;
    en   = 1'b0;
    fcw  = '0;
    step(2);
    chk_out("reset_state", '0);
    rstn = 1'b1;

    // Idle: En=0, FCW=0
    step(1);
    chk_out("idle_0", '0);
    step(1);
    chk_out("idle_1", '0);

    // Half rate
    run_words(20'h80000, 4);
    chk_word("half", 0, 12'h000);
    chk_word("half", 1, 12'h800);
    chk_word("half", 2, 12'h000);
    chk_word("half", 3, 12'h800);

    // Modulo wrap
    run_words(20'hC0000, 5);
    chk_word("wrap", 0, 12'h000);
    chk_word("wrap", 1, 12'hC00);
    chk_word("wrap", 2, 12'h800);
    chk_word("wrap", 3, 12'h400);
    chk_word("wrap", 4, 12'h000);

    // FCW = 0: all-zero words, ISout still pulses
    run_words(20'h00000, 3);
    chk_word("fcw0", 0, 12'h000);
    chk_word("fcw0", 2, 12'h000);

    // FCW change during word 1 (after its frame-start edge)
    got_q.delete();
    fcw = 20'h00100;
    en  = 1'b1;
    step(NCH + 2);
    fcw = 20'h00200;
    step(3 * NCH - 2);
    en  = 1'b0;
    step(1);
    chk_word("fcw_chg", 0, 12'h000);
    chk_word("fcw_chg", 1, 12'h001);
    chk_word("fcw_chg", 2, 12'h002);
    chk_word("fcw_chg", 3, 12'h004);

    // Abort at C=3 of word 1
    fcw = 20'h12345;
    en  = 1'b1;
    step(NCH + 3);
    got_q.delete();
    en  = 1'b0;
    step(1);
    chk_out("abort_idle", '0);
    en  = 1'b1;
    step(1);
    chk_out("abort_restart", {1'b1, 1'b1, 2'b00});
    step(2 * NCH - 1);
    chk_word("abort", 0, 12'h000);
    chk_word("abort", 1, 12'h123);
    en  = 1'b0;
    step(1);

    // Asynchronous reset mid-stream
    fcw = 20'h3F000;
    en  = 1'b1;
    step(NCH + 3);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk_out("async_rst", '0);
    step(1);
    got_q.delete();
    rstn = 1'b1;
    step(2 * NCH);
    chk_word("post_rst", 0, 12'h000);
    chk_word("post_rst", 1, 12'h3F0);

    // Randomized run: FCW changes and En drops at arbitrary cycles
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) fcw = PW'($urandom());
      if ($urandom_range(0, 39) == 0) begin
        en = 1'b0;
        step($urandom_range(1, 3));
        en = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) fcw = '0;
      step(1);
    end
    en = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
